// File: rtl/axi_lite_regfile_if.sv
// AXI4-Lite bus bundle between one master and the register file slave.
// Signal names follow the slave-side port names of the bus.
interface axi_lite_regfile_if #(
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned DATA_W = 32
);
   localparam int unsigned STRB_W = DATA_W / 8;

   logic                s_awvalid;
   logic                s_awready;
   logic [ADDR_W-1:0]   s_awaddr;
   logic                s_wvalid;
   logic                s_wready;
   logic [DATA_W-1:0]   s_wdata;
   logic [STRB_W-1:0]   s_wstrb;
   logic                s_bvalid;
   logic                s_bready;
   logic [1:0]          s_bresp;
   logic                s_arvalid;
   logic                s_arready;
   logic [ADDR_W-1:0]   s_araddr;
   logic                s_rvalid;
   logic                s_rready;
   logic [DATA_W-1:0]   s_rdata;
   logic [1:0]          s_rresp;

   modport slave (
      input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
             s_arvalid, s_araddr, s_rready,
      output s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid,
             s_rdata, s_rresp
   );

   modport master (
      output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
             s_arvalid, s_araddr, s_rready,
      input  s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid,
             s_rdata, s_rresp
   );
endinterface

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite slave register file: NUM_REGS byte-strobed registers with
// independent read/write paths, range checking and per-register write pulses.
module axi_lite_regfile #(
   parameter int unsigned ADDR_W    = 32,
   parameter int unsigned DATA_W    = 32,
   parameter int unsigned NUM_REGS  = 16,
   parameter int unsigned BASE_ADDR = 0
) (
   input  logic                         clk,
   input  logic                         rst_n,
   axi_lite_regfile_if.slave            s,
   output logic [NUM_REGS*DATA_W-1:0]   reg_q,
   output logic [NUM_REGS-1:0]          reg_wr_pulse
);
   localparam int unsigned STRB_W = DATA_W / 8;
   localparam int unsigned LSB    = $clog2(STRB_W);
   localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {ST_IDLE, ST_COMMIT, ST_RESP} wr_state_e;

   wr_state_e           r_state;
   wr_state_e           w_state_nxt;
   logic                r_aw_held, r_w_held;
   logic                w_aw_held_nxt, w_w_held_nxt;
   logic                r_awready, r_wready;
   logic [ADDR_W-1:0]   r_awaddr;
   logic [DATA_W-1:0]   r_wdata;
   logic [STRB_W-1:0]   r_wstrb;
   logic                r_bvalid;
   logic [1:0]          r_bresp;
   logic                r_arready, r_rvalid;
   logic [DATA_W-1:0]   r_rdata;
   logic [1:0]          r_rresp;
   logic [DATA_W-1:0]   r_regs [NUM_REGS];
   logic [NUM_REGS-1:0] r_wr_pulse;
   logic                w_commit, w_b_done;
   logic                w_aw_hs, w_w_hs, w_ar_hs;
   logic                w_wr_in, w_rd_in;
   logic [IDX_W-1:0]    w_wr_idx, w_rd_idx;
   logic [DATA_W-1:0]   w_rd_val;

   // Borrow out of the base subtraction flags addresses below BASE_ADDR.
   function automatic logic in_range(input logic [ADDR_W-1:0] a);
      logic [ADDR_W:0] d;
      d = {1'b0, a} - {1'b0, ADDR_W'(BASE_ADDR)};
      return !d[ADDR_W] && ((d[ADDR_W-1:0] >> LSB) < ADDR_W'(NUM_REGS));
   endfunction

   function automatic logic [IDX_W-1:0] idx_of(input logic [ADDR_W-1:0] a);
      return IDX_W'((a - ADDR_W'(BASE_ADDR)) >> LSB);
   endfunction

   assign w_aw_hs  = s.s_awvalid && r_awready;
   assign w_w_hs   = s.s_wvalid && r_wready;
   assign w_ar_hs  = s.s_arvalid && r_arready;
   assign w_wr_in  = in_range(r_awaddr);
   assign w_wr_idx = idx_of(r_awaddr);
   assign w_rd_in  = in_range(s.s_araddr);
   assign w_rd_idx = idx_of(s.s_araddr);

   always_comb begin
      w_rd_val = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         if (w_rd_idx == IDX_W'(i)) w_rd_val = r_regs[i];
      end
   end

   // Write FSM: state register
   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Write FSM: next state and hold-register control
   always_comb begin
      w_state_nxt   = r_state;
      w_commit      = 1'b0;
      w_b_done      = 1'b0;
      w_aw_held_nxt = r_aw_held | w_aw_hs;
      w_w_held_nxt  = r_w_held | w_w_hs;
      case (r_state)
         ST_IDLE: begin
            if (w_aw_held_nxt && w_w_held_nxt) w_state_nxt = ST_COMMIT;
         end
         ST_COMMIT: begin
            w_commit    = 1'b1;
            w_state_nxt = ST_RESP;
         end
         ST_RESP: begin
            if (s.s_bready) begin
               w_b_done      = 1'b1;
               w_aw_held_nxt = 1'b0;
               w_w_held_nxt  = 1'b0;
               w_state_nxt   = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Write datapath: holds, readies, register update, B channel
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_aw_held  <= 1'b0;
         r_w_held   <= 1'b0;
         r_awready  <= 1'b0;
         r_wready   <= 1'b0;
         r_awaddr   <= '0;
         r_wdata    <= '0;
         r_wstrb    <= '0;
         r_bvalid   <= 1'b0;
         r_bresp    <= RESP_OKAY;
         r_wr_pulse <= '0;
         for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      end else begin
         r_aw_held  <= w_aw_held_nxt;
         r_w_held   <= w_w_held_nxt;
         r_awready  <= !w_aw_held_nxt && (w_state_nxt != ST_RESP);
         r_wready   <= !w_w_held_nxt && (w_state_nxt != ST_RESP);
         if (w_aw_hs) r_awaddr <= s.s_awaddr;
         if (w_w_hs) begin
            r_wdata <= s.s_wdata;
            r_wstrb <= s.s_wstrb;
         end
         if (w_commit) begin
            r_bvalid <= 1'b1;
            r_bresp  <= w_wr_in ? RESP_OKAY : RESP_SLVERR;
         end else if (w_b_done) begin
            r_bvalid <= 1'b0;
         end
         r_wr_pulse <= '0;
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (w_commit && w_wr_in && (w_wr_idx == IDX_W'(i))) begin
               r_wr_pulse[i] <= |r_wstrb;
               for (int unsigned b = 0; b < STRB_W; b++) begin
                  if (r_wstrb[b]) r_regs[i][b*8 +: 8] <= r_wdata[b*8 +: 8];
               end
            end
         end
      end
   end

   // Read path: single outstanding read; rdata samples pre-commit register values
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= '0;
         r_rresp   <= RESP_OKAY;
      end else begin
         r_arready <= !(w_ar_hs || (r_rvalid && !s.s_rready));
         if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_in ? w_rd_val : '0;
            r_rresp  <= w_rd_in ? RESP_OKAY : RESP_SLVERR;
         end else if (r_rvalid && s.s_rready) begin
            r_rvalid <= 1'b0;
         end
      end
   end

   assign s.s_awready  = r_awready;
   assign s.s_wready   = r_wready;
   assign s.s_bvalid   = r_bvalid;
   assign s.s_bresp    = r_bresp;
   assign s.s_arready  = r_arready;
   assign s.s_rvalid   = r_rvalid;
   assign s.s_rdata    = r_rdata;
   assign s.s_rresp    = r_rresp;
   assign reg_wr_pulse = r_wr_pulse;

   for (genvar g = 0; g < NUM_REGS; g++) begin : g_regq
      assign reg_q[g*DATA_W +: DATA_W] = r_regs[g];
   end
endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed bench for axi_lite_regfile (32-bit data, 16 registers, base 0).
module tb_axi_lite_regfile;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned NR = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [NR*DW-1:0] reg_q;
   logic [NR-1:0]    reg_wr_pulse;
   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   axi_lite_regfile_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   axi_lite_regfile #(.ADDR_W(AW), .DATA_W(DW), .NUM_REGS(NR), .BASE_ADDR(0)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .s            (bus.slave),
      .reg_q        (reg_q),
      .reg_wr_pulse (reg_wr_pulse)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [31:0] rq(input int i);
      return reg_q[i*32 +: 32];
   endfunction

   // Bounded wait for B, check response, then complete the handshake
   task automatic b_hs(input string tag, input logic [1:0] exp_resp);
      int n = 0;
      while (bus.s_bvalid !== 1'b1 && n < 20) begin step(); n++; end
      chk({tag, "_bvalid"}, 64'(bus.s_bvalid), 64'(1));
      chk({tag, "_bresp"}, 64'(bus.s_bresp), 64'(exp_resp));
      bus.s_bready = 1'b1;
      step();
      bus.s_bready = 1'b0;
      chk({tag, "_bvalid_clr"}, 64'(bus.s_bvalid), 64'(0));
      chk({tag, "_awready_back"}, 64'(bus.s_awready), 64'(1));
   endtask

   task automatic rd(input string tag, input logic [31:0] addr,
                     input logic [31:0] exp_d, input logic [1:0] exp_r);
      int n = 0;
      while (bus.s_arready !== 1'b1 && n < 20) begin step(); n++; end
      chk({tag, "_arready"}, 64'(bus.s_arready), 64'(1));
      bus.s_araddr  = addr;
      bus.s_arvalid = 1'b1;
      step();
      bus.s_arvalid = 1'b0;
      chk({tag, "_rvalid"}, 64'(bus.s_rvalid), 64'(1));
      chk({tag, "_rdata"}, 64'(bus.s_rdata), 64'(exp_d));
      chk({tag, "_rresp"}, 64'(bus.s_rresp), 64'(exp_r));
      bus.s_rready = 1'b1;
      step();
      bus.s_rready = 1'b0;
      chk({tag, "_rvalid_clr"}, 64'(bus.s_rvalid), 64'(0));
      chk({tag, "_arready_back"}, 64'(bus.s_arready), 64'(1));
   endtask

   initial begin
      bus.s_awvalid = 1'b0; bus.s_awaddr = '0;
      bus.s_wvalid  = 1'b0; bus.s_wdata  = '0; bus.s_wstrb = '0;
      bus.s_bready  = 1'b0;
      bus.s_arvalid = 1'b0; bus.s_araddr = '0;
      bus.s_rready  = 1'b0;

      // Reset held for three cycles
      rst_n = 1'b0;
      repeat (3) step();
      chk("rst_awready", 64'(bus.s_awready), 64'(0));
      chk("rst_wready", 64'(bus.s_wready), 64'(0));
      chk("rst_arready", 64'(bus.s_arready), 64'(0));
      chk("rst_bvalid", 64'(bus.s_bvalid), 64'(0));
      chk("rst_rvalid", 64'(bus.s_rvalid), 64'(0));
      chk("rst_bresp", 64'(bus.s_bresp), 64'(0));
      chk("rst_rresp", 64'(bus.s_rresp), 64'(0));
      chk("rst_rdata", 64'(bus.s_rdata), 64'(0));
      chk("rst_regq_or", 64'(|reg_q), 64'(0));
      chk("rst_pulse", 64'(reg_wr_pulse), 64'(0));
      rst_n = 1'b1;
      step();
      chk("rel_awready", 64'(bus.s_awready), 64'(1));
      chk("rel_wready", 64'(bus.s_wready), 64'(1));
      chk("rel_arready", 64'(bus.s_arready), 64'(1));

      // AW and W together to reg 2
      bus.s_awaddr = 32'h8; bus.s_wdata = 32'hDEADBEEF; bus.s_wstrb = 4'hF;
      bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1;
      step();
      bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
      chk("t1_bvalid_N", 64'(bus.s_bvalid), 64'(0));
      chk("t1_awready_N", 64'(bus.s_awready), 64'(0));
      chk("t1_reg2_N", 64'(rq(2)), 64'(0));
      step();
      chk("t1_bvalid_N1", 64'(bus.s_bvalid), 64'(1));
      chk("t1_reg2", 64'(rq(2)), 64'hDEADBEEF);
      chk("t1_pulse", 64'(reg_wr_pulse), 64'h0004);
      step();
      chk("t1_pulse_clr", 64'(reg_wr_pulse), 64'h0000);
      b_hs("t1", 2'b00);
      rd("t1_rd", 32'h8, 32'hDEADBEEF, 2'b00);

      // W arrives alone, AW three cycles later
      bus.s_wdata = 32'h0000AA00; bus.s_wstrb = 4'b0010; bus.s_wvalid = 1'b1;
      step();
      bus.s_wvalid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         chk("t2_wready_held", 64'(bus.s_wready), 64'(0));
         chk("t2_awready_free", 64'(bus.s_awready), 64'(1));
         if (k < 2) step();
      end
      bus.s_awaddr = 32'h8; bus.s_awvalid = 1'b1;
      step();
      bus.s_awvalid = 1'b0;
      chk("t2_awready_taken", 64'(bus.s_awready), 64'(0));
      step();
      chk("t2_reg2", 64'(rq(2)), 64'hDEADAAEF);
      chk("t2_pulse", 64'(reg_wr_pulse), 64'h0004);
      b_hs("t2", 2'b00);

      // Out-of-range write and read at 0x40
      bus.s_awaddr = 32'h40; bus.s_wdata = 32'h55555555; bus.s_wstrb = 4'hF;
      bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1;
      step();
      bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
      step();
      chk("t3_pulse", 64'(reg_wr_pulse), 64'h0000);
      for (int i = 0; i < 16; i++)
         chk($sformatf("t3_reg%0d", i), 64'(rq(i)), (i == 2) ? 64'hDEADAAEF : 64'h0);
      b_hs("t3", 2'b10);
      rd("t3_rd", 32'h40, 32'h0, 2'b10);
      rd("t3_rd_last", 32'h3C, 32'h0, 2'b00);

      // Back-pressure on B; second write must wait
      bus.s_awaddr = 32'hC; bus.s_wdata = 32'h11111111; bus.s_wstrb = 4'hF;
      bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1;
      step();
      bus.s_awaddr = 32'h10; bus.s_wdata = 32'h22222222;
      step();
      for (int k = 0; k < 5; k++) begin
         chk("t4_bvalid", 64'(bus.s_bvalid), 64'(1));
         chk("t4_bresp", 64'(bus.s_bresp), 64'(0));
         chk("t4_awready", 64'(bus.s_awready), 64'(0));
         chk("t4_wready", 64'(bus.s_wready), 64'(0));
         step();
      end
      chk("t4_reg4_wait", 64'(rq(4)), 64'h0);
      bus.s_bready = 1'b1;
      step();
      bus.s_bready = 1'b0;
      chk("t4_bvalid_clr", 64'(bus.s_bvalid), 64'(0));
      chk("t4_awready_back", 64'(bus.s_awready), 64'(1));
      chk("t4_wready_back", 64'(bus.s_wready), 64'(1));
      step();
      bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
      chk("t4_second_taken", 64'(bus.s_awready), 64'(0));
      step();
      chk("t4_reg3", 64'(rq(3)), 64'h11111111);
      chk("t4_reg4", 64'(rq(4)), 64'h22222222);
      chk("t4_pulse", 64'(reg_wr_pulse), 64'h0010);
      b_hs("t4", 2'b00);

      // Read of reg 1 on the same edge as a commit to reg 1
      bus.s_awaddr = 32'h4; bus.s_wdata = 32'h00001234; bus.s_wstrb = 4'hF;
      bus.s_awvalid = 1'b1; bus.s_wvalid = 1'b1;
      step();
      bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0;
      bus.s_araddr = 32'h4; bus.s_arvalid = 1'b1;
      step();
      bus.s_arvalid = 1'b0;
      chk("t5_rvalid", 64'(bus.s_rvalid), 64'(1));
      chk("t5_rdata_old", 64'(bus.s_rdata), 64'h0);
      chk("t5_reg1", 64'(rq(1)), 64'h00001234);
      chk("t5_pulse", 64'(reg_wr_pulse), 64'h0002);
      bus.s_rready = 1'b1;
      step();
      bus.s_rready = 1'b0;
      b_hs("t5", 2'b00);
      rd("t5_rd_new", 32'h4, 32'h00001234, 2'b00);

      // Reset with an address held discards it
      bus.s_awaddr = 32'h14; bus.s_awvalid = 1'b1;
      step();
      bus.s_awvalid = 1'b0;
      chk("t6_awready_held", 64'(bus.s_awready), 64'(0));
      chk("t6_wready_free", 64'(bus.s_wready), 64'(1));
      rst_n = 1'b0;
      step();
      chk("t6_regq_clr", 64'(|reg_q), 64'(0));
      chk("t6_awready_rst", 64'(bus.s_awready), 64'(0));
      rst_n = 1'b1;
      step();
      chk("t6_awready_rel", 64'(bus.s_awready), 64'(1));
      bus.s_wdata = 32'h99; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
      step();
      bus.s_wvalid = 1'b0;
      step();
      step();
      chk("t6_no_b", 64'(bus.s_bvalid), 64'(0));
      chk("t6_reg5", 64'(rq(5)), 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
